// File: rtl/num_subparser_pkg.sv
// Shared definitions for the numeric argument subparser: ASCII constants,
// character classes and FSM state encoding.
package num_subparser_pkg;

    localparam int DEF_NUM_BITS   = 16;
    localparam int DEF_MAX_DIGITS = 5;

    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_PLUS  = 8'h2B;
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_9     = 8'h39;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_TAB   = 8'h09;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_SEMI  = 8'h3B;

    typedef enum logic [1:0] {
        CLS_DIGIT,
        CLS_SIGN,
        CLS_DELIM,
        CLS_OTHER
    } char_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EVAL,
        ST_FINISH
    } state_e;

    function automatic logic is_delim(input logic [7:0] c);
        return (c == CHAR_SPACE) || (c == CHAR_TAB) || (c == CHAR_CR) ||
               (c == CHAR_LF) || (c == CHAR_SEMI);
    endfunction

endpackage

// File: rtl/num_subparser_if.sv
// Handshake bundle between the parent parser, the subparser and the shared
// character reader.
interface num_subparser_if #(
    parameter int NUM_BITS = 16
);
    logic                trigger;
    logic                done;
    logic                rdy;
    logic                rd_trigger;
    logic                rd_done;
    logic                rd_rdy;
    logic                is_empty;
    logic [7:0]          char_in;
    logic                success;
    logic [NUM_BITS-1:0] value;

    modport slave (
        input  trigger, rd_done, rd_rdy, is_empty, char_in,
        output done, rdy, rd_trigger, success, value
    );

    modport master (
        output trigger, rd_done, rd_rdy, is_empty, char_in,
        input  done, rdy, rd_trigger, success, value
    );
endinterface

// File: rtl/num_subparser_decoder.sv
// Combinational ASCII classifier: digit / sign / delimiter / other, plus the
// binary value of a digit character.
module decimal_char_decoder
    import num_subparser_pkg::*;
(
    input  logic [7:0]  ch,
    output char_class_e cls,
    output logic [3:0]  digit
);

    always_comb begin
        cls   = CLS_OTHER;
        digit = '0;
        if ((ch >= CHAR_0) && (ch <= CHAR_9)) begin
            cls   = CLS_DIGIT;
            // '0' is 0x30, so the low nibble is the digit value
            digit = ch[3:0];
        end else if ((ch == CHAR_MINUS) || (ch == CHAR_PLUS)) begin
            cls = CLS_SIGN;
        end else if (is_delim(ch)) begin
            cls = CLS_DELIM;
        end
    end

endmodule

// File: rtl/num_subparser.sv
// Parses one signed decimal integer from the character reader and returns it
// with a pass/fail flag to the parent parser.
module num_subparser
    import num_subparser_pkg::*;
#(
    parameter int NUM_BITS   = DEF_NUM_BITS,
    parameter int MAX_DIGITS = DEF_MAX_DIGITS
) (
    input  logic            clk,
    input  logic            reset,
    num_subparser_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [NUM_BITS:0] POS_LIMIT = {2'b00, {(NUM_BITS-1){1'b1}}};
    localparam logic [NUM_BITS:0] NEG_LIMIT = {2'b01, {(NUM_BITS-1){1'b0}}};

    state_e            state;
    state_e            state_next;
    logic [NUM_BITS:0] mag;
    logic              neg;
    logic              sign_seen;
    logic [CNT_W-1:0]  digits;
    logic [7:0]        ch_q;
    char_class_e       cls;
    logic [3:0]        digit;

    logic do_start;
    logic do_latch;
    logic do_sign;
    logic do_digit;
    logic do_finish;
    logic finish_ok;
    logic has_digits;
    logic range_ok;

    decimal_char_decoder u_dec (
        .ch    (ch_q),
        .cls   (cls),
        .digit (digit)
    );

    assign has_digits = (digits != '0);
    assign range_ok   = neg ? (mag <= NEG_LIMIT) : (mag <= POS_LIMIT);

    assign bus.rdy        = (state == ST_IDLE);
    assign bus.done       = (state == ST_FINISH);
    assign bus.rd_trigger = (state == ST_REQ) && !bus.is_empty && bus.rd_rdy;

    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_latch   = 1'b0;
        do_sign    = 1'b0;
        do_digit   = 1'b0;
        do_finish  = 1'b0;
        finish_ok  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.trigger) begin
                    do_start   = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // end of input takes priority over issuing another read
                if (bus.is_empty) begin
                    do_finish  = 1'b1;
                    finish_ok  = has_digits && range_ok;
                    state_next = ST_FINISH;
                end else if (bus.rd_rdy) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.rd_done) begin
                    do_latch   = 1'b1;
                    state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                case (cls)
                    CLS_SIGN: begin
                        if (!has_digits && !sign_seen) begin
                            do_sign    = 1'b1;
                            state_next = ST_REQ;
                        end else begin
                            do_finish  = 1'b1;
                            state_next = ST_FINISH;
                        end
                    end
                    CLS_DIGIT: begin
                        if (digits == CNT_W'(MAX_DIGITS)) begin
                            do_finish  = 1'b1;
                            state_next = ST_FINISH;
                        end else begin
                            do_digit   = 1'b1;
                            state_next = ST_REQ;
                        end
                    end
                    CLS_DELIM: begin
                        do_finish  = 1'b1;
                        finish_ok  = has_digits && range_ok;
                        state_next = ST_FINISH;
                    end
                    default: begin
                        do_finish  = 1'b1;
                        state_next = ST_FINISH;
                    end
                endcase
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mag         <= '0;
            neg         <= 1'b0;
            sign_seen   <= 1'b0;
            digits      <= '0;
            ch_q        <= '0;
            bus.success <= 1'b0;
            bus.value   <= '0;
        end else begin
            state <= state_next;
            if (do_start) begin
                mag         <= '0;
                neg         <= 1'b0;
                sign_seen   <= 1'b0;
                digits      <= '0;
                bus.success <= 1'b0;
                bus.value   <= '0;
            end
            if (do_latch) begin
                ch_q <= bus.char_in;
            end
            if (do_sign) begin
                sign_seen <= 1'b1;
                neg       <= (ch_q == CHAR_MINUS);
            end
            if (do_digit) begin
                // mag*10 as mag*8 + mag*2
                mag    <= (mag << 3) + (mag << 1) + (NUM_BITS+1)'(digit);
                digits <= digits + 1'b1;
            end
            if (do_finish) begin
                bus.success <= finish_ok;
                if (!finish_ok) begin
                    bus.value <= '0;
                end else if (neg) begin
                    bus.value <= -mag[NUM_BITS-1:0];
                end else begin
                    bus.value <= mag[NUM_BITS-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_num_subparser.sv
// Directed bench for num_subparser: a behavioural character reader feeds
// strings, a scoreboard holds the expected outcome of each parse.
module tb_num_subparser;

    typedef struct {
        bit          succ;
        logic [15:0] val;
        int          reads;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    exp_t  sb[$];
    string cur_s;
    int    cur_len = 0;
    int    rd_idx  = 0;
    int    rd_lat  = 0;
    int    n_reads = 0;
    int    done_cnt = 0;
    int    n_pass  = 0;
    int    n_total = 0;

    num_subparser_if #(.NUM_BITS(16)) bus ();

    num_subparser #(.NUM_BITS(16), .MAX_DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.is_empty = (rd_idx >= cur_len);

    // Character reader: answers each rd_trigger after rd_lat extra cycles
    initial begin
        bus.rd_done = 1'b0;
        bus.char_in = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.rd_trigger === 1'b1) begin
                n_reads++;
                @(posedge clk); #1;
                repeat (rd_lat) begin
                    @(posedge clk); #1;
                end
                bus.rd_done = 1'b1;
                bus.char_in = (rd_idx < cur_len) ? cur_s[rd_idx] : 8'h00;
                rd_idx++;
                @(posedge clk); #1;
                bus.rd_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_parse(input string s, input bit es, input logic [15:0] ev, input int er);
        exp_t e;
        e.succ  = es;
        e.val   = ev;
        e.reads = er;
        sb.push_back(e);
        cur_s    = s;
        cur_len  = s.len();
        rd_idx   = 0;
        n_reads  = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        bus.trigger = 1'b1;
        @(posedge clk); #1;
        bus.trigger = 1'b0;
    endtask

    task automatic finish_parse(input string tag);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_success"}, 32'(bus.success), 32'(e.succ));
            chk({tag, "_value"}, 32'(bus.value), 32'(e.val));
            chk({tag, "_reads"}, n_reads, e.reads);
        end
        @(negedge clk);
        chk({tag, "_rdy_after"}, 32'(bus.rdy), 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, done_cnt, 32'd1);
    endtask

    task automatic run(input string s, input bit es, input logic [15:0] ev, input int er, input string tag);
        start_parse(s, es, ev, er);
        finish_parse(tag);
    endtask

    initial begin
        bus.trigger = 1'b0;
        bus.rd_rdy  = 1'b1;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(bus.rdy), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rd_trigger", 32'(bus.rd_trigger), 32'd0);
        chk("rst_success", 32'(bus.success), 32'd0);
        chk("rst_value", 32'(bus.value), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        start_parse("123 ", 1'b1, 16'd123, 4);
        chk("first_rd_latency", 32'(bus.rd_trigger), 32'd1);
        finish_parse("p123");

        run("-45\n",   1'b1, 16'hFFD3, 4, "neg45");
        run("+",       1'b0, 16'h0000, 1, "plus_only");
        run("7",       1'b1, 16'h0007, 1, "seven_eof");
        run("",        1'b0, 16'h0000, 0, "empty");
        run("12a",     1'b0, 16'h0000, 3, "bad_char");
        run("+-1",     1'b0, 16'h0000, 2, "two_signs");
        run("32767 ",  1'b1, 16'h7FFF, 6, "pos_max");
        run("32768 ",  1'b0, 16'h0000, 6, "pos_ovf");
        run("-32768 ", 1'b1, 16'h8000, 7, "neg_max");
        run("123456",  1'b0, 16'h0000, 6, "six_digits");

        // reader stalled, slow responses, and a trigger while busy
        bus.rd_rdy = 1'b0;
        rd_lat     = 3;
        start_parse("-8;", 1'b1, 16'hFFF8, 3);
        repeat (5) @(negedge clk);
        chk("stall_no_read", n_reads, 32'd0);
        @(posedge clk); #1;
        bus.trigger = 1'b1;
        @(negedge clk);
        chk("busy_rdy", 32'(bus.rdy), 32'd0);
        @(posedge clk); #1;
        bus.trigger = 1'b0;
        bus.rd_rdy  = 1'b1;
        finish_parse("stalled");
        rd_lat = 0;

        run("-45;", 1'b1, 16'hFFD3, 4, "pre_reset");

        // reset while waiting on the reader aborts the parse
        rd_lat = 6;
        start_parse("99 ", 1'b0, 16'h0000, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rdy", 32'(bus.rdy), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_rd_trigger", 32'(bus.rd_trigger), 32'd0);
        chk("abort_success", 32'(bus.success), 32'd0);
        chk("abort_value", 32'(bus.value), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt, 32'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        rd_lat = 0;

        run("9 ", 1'b1, 16'h0009, 2, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
